// File: rtl/sys_bus_arbiter_if.sv
// Shared system-bus handshake between the arbiter (master side) and the
// memory/peripheral that answers it (slave side).
interface sys_bus_arbiter_if #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 8
) ();
  logic                 ale_en;
  logic [MEM_DEPTH-1:0] addr_input;
  logic                 bus_write_en;
  logic                 bus_read_en;
  logic [MEM_WIDTH-1:0] data_write;
  logic [MEM_WIDTH-1:0] data_read;
  logic                 bus_ready;

  modport master (
    output ale_en, addr_input, bus_write_en, bus_read_en, data_write,
    input  data_read, bus_ready
  );

  modport slave (
    input  ale_en, addr_input, bus_write_en, bus_read_en, data_write,
    output data_read, bus_ready
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin arbiter and single-beat transaction sequencer for
// the shared system bus: IDLE -> ALE -> CMD -> WAIT -> DONE -> IDLE.
// Optional WAIT-state timeout is built only when ARB_TIMEOUT_EN is defined.
module sys_bus_arbiter #(
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [MEM_DEPTH-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [MEM_DEPTH-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_wdata,
  output logic                 m0_gnt,
  output logic                 m0_done,
  output logic [MEM_WIDTH-1:0] m0_rdata,
  output logic                 m0_err,
  output logic                 m1_gnt,
  output logic                 m1_done,
  output logic [MEM_WIDTH-1:0] m1_rdata,
  output logic                 m1_err,
  sys_bus_arbiter_if.master    bus,
  output logic                 owner,
  output logic [2:0]           arb_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALE  = 3'd1,
    S_CMD  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [MEM_DEPTH-1:0] addr;
    logic [MEM_WIDTH-1:0] wdata;
  } req_t;

  state_t               state;
  logic                 last_owner;
  logic                 own;
  req_t                 req_q;
  logic [MEM_WIDTH-1:0] rdata_q;
  logic                 pick;
  logic                 err_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the non-last owner.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) pick = ~last_owner;
    else if (m1_req)      pick = 1'b1;
  end

  // Sequencer FSM with latched request fields and read/err capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_owner <= 1'b1;
      own        <= 1'b0;
      req_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            own     <= pick;
            req_q   <= pick ? req_t'{m1_we, m1_addr, m1_wdata}
                            : req_t'{m0_we, m0_addr, m0_wdata};
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= S_ALE;
          end
        end
        S_ALE: state <= S_CMD;
        S_CMD: begin
`ifdef ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Ready beats the timeout when both land on the same edge.
          if (bus.bus_ready) begin
            rdata_q <= req_q.we ? '0 : bus.data_read;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          last_owner <= own;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus side decoded purely from registered state and latched fields.
  always_comb begin
    bus.ale_en       = (state == S_ALE);
    bus.addr_input   = (state == S_ALE || state == S_CMD) ? req_q.addr : '0;
    bus.bus_write_en = (state == S_CMD) &&  req_q.we;
    bus.bus_read_en  = (state == S_CMD) && !req_q.we;
    bus.data_write   = ((state == S_CMD || state == S_WAIT) && req_q.we) ? req_q.wdata : '0;
  end

  // Per-master response decode; non-owners always see zeros.
  logic [1:0]                gnt_v, done_v, err_v;
  logic [1:0][MEM_WIDTH-1:0] rdata_v;

  for (genvar g = 0; g < 2; g++) begin : g_mst
    assign gnt_v[g]   = (state == S_ALE)  && (own == 1'(g));
    assign done_v[g]  = (state == S_DONE) && (own == 1'(g));
    assign rdata_v[g] = done_v[g] ? rdata_q : '0;
`ifdef ARB_TIMEOUT_EN
    assign err_v[g]   = done_v[g] && err_q;
`else
    assign err_v[g]   = 1'b0;
`endif
  end

`ifndef ARB_TIMEOUT_EN
  logic unused_err;
  assign unused_err = err_q;
`endif

  assign m0_gnt    = gnt_v[0];
  assign m1_gnt    = gnt_v[1];
  assign m0_done   = done_v[0];
  assign m1_done   = done_v[1];
  assign m0_rdata  = rdata_v[0];
  assign m1_rdata  = rdata_v[1];
  assign m0_err    = err_v[0];
  assign m1_err    = err_v[1];
  assign owner     = own;
  assign arb_state = state;

endmodule
